// File: rtl/instr_encoder.sv
// instr_encoder: packs R/I/J instruction fields into a 32-bit word and queues it, tagged with a PC, in a 4-entry FIFO.
// Define ENC_CHECK_EN to reject R sets with nonzero opcode and J sets whose opcode is not 0x02/0x03.
module instr_encoder (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [1:0]  fmt,
   input  logic [5:0]  opcode,
   input  logic [4:0]  rs,
   input  logic [4:0]  rt,
   input  logic [4:0]  rd,
   input  logic [4:0]  shamt,
   input  logic [5:0]  funct,
   input  logic [15:0] imm,
   input  logic [25:0] address,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_instr,
   output logic [31:0] out_pc,
   output logic [2:0]  count,
   output logic        err
);

   localparam logic [31:0] PC_RESET = 32'h0000_3000;

   // Handshake: a set moves on a rising edge where in_valid && in_ready; a word
   // leaves on a rising edge where out_valid && out_ready. in_ready and
   // out_valid come from registered occupancy only.
   logic [31:0] instr_mem_q [4];
   logic [31:0] instr_mem_d [4];
   logic [31:0] pc_mem_q    [4];
   logic [31:0] pc_mem_d    [4];
   logic [1:0]  wr_ptr_q, wr_ptr_d;
   logic [1:0]  rd_ptr_q, rd_ptr_d;
   logic [2:0]  count_q, count_d;
   logic [31:0] pc_q, pc_d;
   logic        err_q, err_d;

   logic [31:0] enc_word;
   logic        reject;
   logic        accept;
   logic        push;
   logic        pop;

   assign in_ready  = (count_q != 3'd4);
   assign out_valid = (count_q != 3'd0);
   assign accept    = in_valid & in_ready;
   assign push      = accept & ~reject;
   assign pop       = out_valid & out_ready;

   always_comb begin
      enc_word = 32'h0;
      case (fmt)
         2'b00:   enc_word = {opcode, rs, rt, rd, shamt, funct};
         2'b01:   enc_word = {opcode, rs, rt, imm};
         2'b10:   enc_word = {opcode, address};
         default: enc_word = 32'h0;
      endcase
   end

   always_comb begin
      reject = (fmt == 2'b11);
`ifdef ENC_CHECK_EN
      if ((fmt == 2'b00) && (opcode != 6'h00)) begin
         reject = 1'b1;
      end
      if ((fmt == 2'b10) && (opcode != 6'h02) && (opcode != 6'h03)) begin
         reject = 1'b1;
      end
`endif
   end

   always_comb begin
      instr_mem_d = instr_mem_q;
      pc_mem_d    = pc_mem_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      pc_d        = pc_q;
      count_d     = count_q;
      // A rejected set is still consumed; only the err pulse records it.
      err_d       = accept & reject;
      if (push) begin
         instr_mem_d[wr_ptr_q] = enc_word;
         pc_mem_d[wr_ptr_q]    = pc_q;
         wr_ptr_d              = wr_ptr_q + 2'd1;
         pc_d                  = pc_q + 32'd4;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + 2'd1;
      end
      case ({push, pop})
         2'b10:   count_d = count_q + 3'd1;
         2'b01:   count_d = count_q - 3'd1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 4; i++) begin
            instr_mem_q[i] <= 32'h0;
            pc_mem_q[i]    <= 32'h0;
         end
         wr_ptr_q <= 2'd0;
         rd_ptr_q <= 2'd0;
         count_q  <= 3'd0;
         pc_q     <= PC_RESET;
         err_q    <= 1'b0;
      end else begin
         instr_mem_q <= instr_mem_d;
         pc_mem_q    <= pc_mem_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         pc_q        <= pc_d;
         err_q       <= err_d;
      end
   end

   // Outputs read zero whenever the FIFO is empty so no stale head is visible.
   assign out_instr = out_valid ? instr_mem_q[rd_ptr_q] : 32'h0;
   assign out_pc    = out_valid ? pc_mem_q[rd_ptr_q]    : 32'h0;
   assign count     = count_q;
   assign err       = err_q;

endmodule
